// File: rtl/prio_sel_gen8_pkg.sv
// Shared select-encoding package for the jet-finding 8:1 priority mux path.
// Imported by prio_sel_gen8, its interface and the prio_enc8 sub-module.
package jet_mux_pkg;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned SEL_W = 4;

  // 4'b0iii selects input iii; 4'b1000 makes the mux emit 0.
  localparam logic [SEL_W-1:0] SEL_NONE = 4'b1000;

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  function automatic logic [3:0] popcount8(input logic [N_IN-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_sel_gen8_if.sv
// Burst/select bus between the jet-candidate valid logic and prio_sel_gen8.
// master: burst source and select consumer; slave: the select generator.
interface prio_sel_gen8_if #(
  parameter int unsigned TAG_WIDTH = 8
);
  import jet_mux_pkg::*;

  logic                 load;
  logic [N_IN-1:0]      mask;
  logic [TAG_WIDTH-1:0] tag_in;
  logic                 hold;
  logic                 ready;
  logic [SEL_W-1:0]     sel;
  logic                 sel_valid;
  logic                 last;
  logic [TAG_WIDTH-1:0] tag_out;
  logic [3:0]           n_set;

  modport master (
    output load, mask, tag_in, hold,
    input  ready, sel, sel_valid, last, tag_out, n_set
  );

  modport slave (
    input  load, mask, tag_in, hold,
    output ready, sel, sel_valid, last, tag_out, n_set
  );

endinterface

// File: rtl/prio_sel_gen8_prio_enc8.sv
// prio_enc8: combinational first-set-bit finder over an 8-bit vector.
// Default picks the lowest set index; PRIO_SEL_GEN8_MSB_FIRST_EN picks the highest.
module prio_enc8
  import jet_mux_pkg::*;
(
  input  logic [N_IN-1:0] vec,
  output logic [2:0]      idx,
  output logic            any
);

  // Scan so that the preferred bit is the last one to overwrite idx.
  always_comb begin
    idx = '0;
    any = |vec;
`ifdef PRIO_SEL_GEN8_MSB_FIRST_EN
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (vec[i]) idx = 3'(i);
    end
`else
    for (int unsigned i = N_IN; i > 0; i--) begin
      if (vec[i-1]) idx = 3'(i - 1);
    end
`endif
  end

endmodule

// File: rtl/prio_sel_gen8.sv
// prio_sel_gen8: issues one mux select per cycle for each set bit of a burst
// mask, with burst tag, popcount and last marker.
// Optional macro PRIO_SEL_GEN8_MSB_FIRST_EN: scan highest index first.
module prio_sel_gen8
  import jet_mux_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  prio_sel_gen8_if.slave   bus
);

  state_e               state_q, state_d;
  logic [N_IN-1:0]      pend_q, pend_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 sel_valid_q, sel_valid_d;
  logic                 last_q, last_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [3:0]           n_set_q, n_set_d;

  logic [N_IN-1:0]      enc_vec;
  logic [N_IN-1:0]      pend_next;
  logic [2:0]           enc_idx;
  logic                 enc_any;

  // In IDLE the first element comes straight from the incoming mask so it
  // can be emitted on the load edge; in SCAN it comes from the pending bits.
  assign enc_vec   = (state_q == IDLE) ? bus.mask : pend_q;
  assign pend_next = enc_vec & ~(8'(1) << enc_idx);

  prio_enc8 u_enc (
    .vec (enc_vec),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign bus.ready     = (state_q == IDLE) && !bus.hold;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.last      = last_q;
  assign bus.tag_out   = tag_q;
  assign bus.n_set     = n_set_q;

  // Next-state and next-output computation; hold keeps every register.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    last_d      = last_q;
    tag_d       = tag_q;
    n_set_d     = n_set_q;
    if (!bus.hold) begin
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            tag_d   = bus.tag_in;
            n_set_d = popcount8(bus.mask);
            if (enc_any) begin
              sel_d       = {1'b0, enc_idx};
              sel_valid_d = 1'b1;
              pend_d      = pend_next;
              last_d      = (pend_next == '0);
              state_d     = (pend_next == '0) ? IDLE : SCAN;
            end else begin
              sel_d       = SEL_NONE;
              sel_valid_d = 1'b1;
              last_d      = 1'b1;
              pend_d      = '0;
            end
          end else begin
            sel_d       = SEL_NONE;
            sel_valid_d = 1'b0;
            last_d      = 1'b0;
          end
        end
        SCAN: begin
          sel_d       = {1'b0, enc_idx};
          sel_valid_d = 1'b1;
          pend_d      = pend_next;
          last_d      = (pend_next == '0);
          state_d     = (pend_next == '0) ? IDLE : SCAN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs; synchronous reset dominates load and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      sel_q       <= SEL_NONE;
      sel_valid_q <= 1'b0;
      last_q      <= 1'b0;
      tag_q       <= '0;
      n_set_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      n_set_q     <= n_set_d;
    end
  end

endmodule

// File: tb/tb_prio_sel_gen8.sv
// Self-checking bench for prio_sel_gen8: directed bursts from the test plan,
// then random traffic, all compared against a queue-based burst model.
module tb_prio_sel_gen8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prio_sel_gen8_if #(.TAG_WIDTH(8)) bus ();

  prio_sel_gen8 #(.TAG_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: the elements still to be emitted, in emission order.
  int         q[$];
  int         m_sel;
  int         m_valid;
  int         m_last;
  int         m_tag;
  int         m_nset;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sel = 8; m_valid = 0; m_last = 0; m_tag = 0; m_nset = 0;
  endtask

  task automatic emit_next();
    m_sel   = q.pop_front();
    m_valid = 1;
    m_last  = (q.size() == 0) ? 1 : 0;
  endtask

  // One clock: check ready, advance the model, clock, check registered outputs.
  task automatic step();
    int cnt;
    #1;
    chk("ready", 32'(bus.ready), 32'((q.size() == 0) && !bus.hold));
    if (rst) begin
      model_reset();
    end else if (!bus.hold) begin
      if (q.size() == 0) begin
        if (bus.load) begin
          cnt = 0;
`ifdef PRIO_SEL_GEN8_MSB_FIRST_EN
          for (int i = 7; i >= 0; i--) if (bus.mask[i]) begin q.push_back(i); cnt++; end
`else
          for (int i = 0; i < 8; i++) if (bus.mask[i]) begin q.push_back(i); cnt++; end
`endif
          m_tag  = int'(bus.tag_in);
          m_nset = cnt;
          if (cnt == 0) begin
            m_sel = 8; m_valid = 1; m_last = 1;
          end else begin
            emit_next();
          end
        end else begin
          m_sel = 8; m_valid = 0; m_last = 0;
        end
      end else begin
        emit_next();
      end
    end
    @(posedge clk);
    #1;
    chk("sel",       32'(bus.sel),       32'(m_sel));
    chk("sel_valid", 32'(bus.sel_valid), 32'(m_valid));
    chk("last",      32'(bus.last),      32'(m_last));
    chk("tag_out",   32'(bus.tag_out),   32'(m_tag));
    chk("n_set",     32'(bus.n_set),     32'(m_nset));
  endtask

  int seq_a[4];
  int seq_m[3];

  initial begin
`ifdef PRIO_SEL_GEN8_MSB_FIRST_EN
    seq_a = '{7, 5, 2, 0};
    seq_m = '{6, 3, 0};
`else
    seq_a = '{0, 2, 5, 7};
    seq_m = '{0, 3, 6};
`endif
    rst = 1'b1;
    bus.load = 1'b0; bus.mask = '0; bus.tag_in = '0; bus.hold = 1'b0;
    model_reset();
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    step();
    step();
    chk("idle_sel_none", 32'(bus.sel), 32'h8);

    // Burst 8'b1010_0101, tag 3C.
    bus.load = 1'b1; bus.mask = 8'hA5; bus.tag_in = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.load = 1'b0;
      chk("seqA_sel", 32'(bus.sel), 32'(seq_a[i]));
      chk("seqA_last", 32'(bus.last), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("seqA_tag", 32'(bus.tag_out), 32'h3C);
    chk("seqA_nset", 32'(bus.n_set), 32'd4);
    step();

    // Empty mask: a single terminator cycle.
    bus.load = 1'b1; bus.mask = 8'h00; bus.tag_in = 8'h11;
    step();
    bus.load = 1'b0;
    chk("empty_sel", 32'(bus.sel), 32'h8);
    chk("empty_last", 32'(bus.last), 32'd1);
    step();
    chk("empty_after_valid", 32'(bus.sel_valid), 32'd0);

    // 8'hFF with a 2-cycle hold after sel=3, then back-to-back load on last.
    bus.load = 1'b1; bus.mask = 8'hFF; bus.tag_in = 8'h77;
    step();
    bus.load = 1'b0;
    step(); step(); step();
    bus.hold = 1'b1;
    step(); step();
    bus.hold = 1'b0;
    step(); step(); step(); step();
    chk("ff_last", 32'(bus.last), 32'd1);
    bus.load = 1'b1; bus.mask = 8'h12; bus.tag_in = 8'h5A;
    step();
    bus.load = 1'b0;
    chk("b2b_valid", 32'(bus.sel_valid), 32'd1);
    step();
    step();

    // Reset mid-burst with load high.
    bus.load = 1'b1; bus.mask = 8'h0F; bus.tag_in = 8'h42;
    step();
    bus.load = 1'b0;
    step(); step();
    rst = 1'b1; bus.load = 1'b1; bus.mask = 8'hF0;
    step();
    chk("rst_sel", 32'(bus.sel), 32'h8);
    rst = 1'b0; bus.load = 1'b0;
    step();

    // 8'b0100_1001 ordering.
    bus.load = 1'b1; bus.mask = 8'h49; bus.tag_in = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.load = 1'b0;
      chk("seqM_sel", 32'(bus.sel), 32'(seq_m[i]));
    end
    step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bus.load   = ($urandom_range(0, 1) == 1);
      bus.mask   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bus.tag_in = 8'($urandom);
      bus.hold   = ($urandom_range(0, 4) == 0);
      rst        = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
